dsp_divider: RTL and testbench

Memory-mapped iterative 32-bit integer divider. It sits beside the multiplier in the DSP peripheral space, downstream of the address decoder and bus arbiter, on the 2x (VDP) clock. The CPU writes a dividend, then a divisor, which starts the operation; quotient and remainder reads stall on the bus until the result is ready. Results follow RISC-V DIV/DIVU/REM/REMU semantics, including the divide-by-zero and overflow cases.

---
 rtl/dsp_divider.sv | 239 +++++++++++++++++++++++
 tb/tb_dsp_divider.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_divider.sv
// ---------------------------------------------------------------------------
// dsp_divider
//
// Memory-mapped iterative 32-bit integer divider for the DSP peripheral
// space on the 2x (VDP) clock. The CPU writes the dividend, then writes the
// divisor to one of the start registers. That write launches a restoring
// divide that produces one quotient bit per cycle. The result follows RISC-V
// DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.
//
// Register map (word index on address):
//   0 DIVIDEND  (W/R) operand register
//   1 START_U   (W)   latch divisor, start unsigned divide
//   2 START_S   (W)   latch divisor, start signed divide
//   4 QUOTIENT  (R)   stalls while a divide is in flight
//   5 REMAINDER (R)   stalls while a divide is in flight
//   6 STATUS    (R)   bit0 = busy
//   Writes to 3..7 are acknowledged and ignored; reads of 1..3 and 7 return 0.
//
// Ports:
//   clk        2x / VDP clock
//   resetn     synchronous, active-low reset
//   en         single-cycle access strobe from the address decoder
//   write_en   qualifies en as a write
//   address    register word index (cpu_address[4:2])
//   write_data write value
//   read_data  read value, non-zero only in the cycle ready is high
//   ready      one-cycle access-complete pulse
//   busy       divide in progress (registered)
// ---------------------------------------------------------------------------
module dsp_divider #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        write_en,
  input  logic [2:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(ITERATIONS) + 1;

  localparam logic [2:0] ADDR_DIVIDEND  = 3'd0;
  localparam logic [2:0] ADDR_START_U   = 3'd1;
  localparam logic [2:0] ADDR_START_S   = 3'd2;
  localparam logic [2:0] ADDR_QUOTIENT  = 3'd4;
  localparam logic [2:0] ADDR_REMAINDER = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITERATE,
    S_FIXUP
  } state_t;

  // Magnitude of an operand. In unsigned mode the value passes through.
  // The magnitude of the most negative value wraps to itself, and the
  // datapath then treats it as the unsigned 2^31.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic              is_signed);
    return (is_signed && x[DATA_W-1]) ? -x : x;
  endfunction

  // Conditional two's-complement negation used for the final sign fix.
  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] x,
                                                  input logic              do_neg);
    return do_neg ? -x : x;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rd_pending;
  logic               rd_sel_rem;

  logic [DATA_W-1:0]  dividend_reg;
  logic [DATA_W-1:0]  quotient_reg;
  logic [DATA_W-1:0]  remainder_reg;

  // Working registers. dvd shifts left each iteration and collects the quotient
  // bits from the bottom, so it holds the quotient magnitude once all
  // iterations finish.
  logic [DATA_W-1:0]  dvd;
  logic [DATA_W-1:0]  dvs;
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  orig_dvd;
  logic               div_zero;
  logic               ovf;
  logic               neg_q;
  logic               neg_r;

  logic               acc_rd;
  logic               acc_wr;
  logic               start_wr;
  logic               start_signed;
  logic               res_rd;
  logic [DATA_W-1:0]  shifted;
  logic signed [DATA_W:0] trial;
  logic [DATA_W-1:0]  fix_q;
  logic [DATA_W-1:0]  fix_r;
  logic [DATA_W-1:0]  rd_mux;

  assign acc_rd       = en && !write_en;
  assign acc_wr       = en && write_en;
  assign start_signed = (address == ADDR_START_S);
  assign start_wr     = acc_wr && ((address == ADDR_START_U) || start_signed);
  assign res_rd       = acc_rd && ((address == ADDR_QUOTIENT) || (address == ADDR_REMAINDER));

  // The partial remainder never reaches bit 31 before a shift: after k
  // iterations it is below 2^k. So rem[30:0] plus the next dividend bit is
  // the full shifted value. The 33-bit subtract yields the borrow as the sign.
  assign shifted = {rem[DATA_W-2:0], dvd[DATA_W-1]};
  assign trial   = $signed({1'b0, shifted}) - $signed({1'b0, dvs});

  // Divide-by-zero first, then signed overflow, then the ordinary sign fix.
  always_comb begin
    fix_q = negate_if(dvd, neg_q);
    fix_r = negate_if(rem, neg_r);
    if (div_zero) begin
      fix_q = ALL_ONES;
      fix_r = orig_dvd;
    end else if (ovf) begin
      fix_q = MOST_NEG;
      fix_r = '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DIVIDEND:  rd_mux = dividend_reg;
      ADDR_QUOTIENT:  rd_mux = quotient_reg;
      ADDR_REMAINDER: rd_mux = remainder_reg;
      ADDR_STATUS:    rd_mux = {{(DATA_W-1){1'b0}}, busy};
      default:        rd_mux = '0;
    endcase
  end

  // ---- iteration datapath: operand load on start, one restoring step per cycle
  always_ff @(posedge clk) begin
    if (start_wr) begin
      dvd      <= magnitude(dividend_reg, start_signed);
      dvs      <= magnitude(write_data, start_signed);
      rem      <= '0;
      orig_dvd <= dividend_reg;
      div_zero <= (write_data == '0);
      ovf      <= start_signed && (dividend_reg == MOST_NEG) && (write_data == ALL_ONES);
      neg_q    <= start_signed && (dividend_reg[DATA_W-1] ^ write_data[DATA_W-1]);
      neg_r    <= start_signed && dividend_reg[DATA_W-1];
    end else if (state == S_ITERATE) begin
      if (!trial[DATA_W]) begin
        rem <= trial[DATA_W-1:0];
        dvd <= {dvd[DATA_W-2:0], 1'b1};
      end else begin
        rem <= shifted;
        dvd <= {dvd[DATA_W-2:0], 1'b0};
      end
    end
  end

  // ---- control, bus response and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      ready         <= 1'b0;
      read_data     <= '0;
      rd_pending    <= 1'b0;
      rd_sel_rem    <= 1'b0;
      dividend_reg  <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      ready     <= 1'b0;
      read_data <= '0;

      case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end
        S_ITERATE: begin
          if (cnt == '0) begin
            state <= S_FIXUP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIXUP: begin
          quotient_reg  <= fix_q;
          remainder_reg <= fix_r;
          state         <= S_IDLE;
          busy          <= 1'b0;
          // A result read stalled during ITERATE, or one arriving in this
          // very cycle, is answered straight from the fixup result.
          if (rd_pending || res_rd) begin
            ready      <= 1'b1;
            read_data  <= (rd_pending ? rd_sel_rem : address[0]) ? fix_r : fix_q;
            rd_pending <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (acc_wr) begin
        ready <= 1'b1;
        if (address == ADDR_DIVIDEND) begin
          dividend_reg <= write_data;
        end
        // A start overrides whatever the FSM was doing, including a restart
        // of a divide already in flight.
        if (start_wr) begin
          state <= S_ITERATE;
          cnt   <= CNT_W'(ITERATIONS - 1);
          busy  <= 1'b1;
        end
      end

      if (acc_rd && !(res_rd && (state != S_IDLE))) begin
        ready     <= 1'b1;
        read_data <= rd_mux;
      end

      if (res_rd && (state == S_ITERATE)) begin
        rd_pending <= 1'b1;
        rd_sel_rem <= address[0];
      end
    end
  end

endmodule

// File: tb/tb_dsp_divider.sv
// ---------------------------------------------------------------------------
// tb_dsp_divider
//
// Scoreboard bench for dsp_divider. Each bus access pushes its expected
// read_data, which is zero for writes, onto a queue. A negedge monitor pops
// and compares on every ready pulse. It also requires read_data to be zero
// whenever ready is low. Timing and status observations from the stimulus
// thread go through a second queue that the same monitor checks, so one
// process owns the counters.
// ---------------------------------------------------------------------------
module tb_dsp_divider;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        write_en = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;

  always #5 clk = ~clk;

  dsp_divider #(.ITERATIONS(ITER)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .write_en   (write_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .busy       (busy)
  );

  typedef struct {
    string       nm;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  chk_t        chk_q[$];

  int n_vec = 0;
  int n_err = 0;
  int acks  = 0;

  // Monitor: sole owner of the counters.
  chk_t        m_c;
  logic [31:0] m_e;
  string       m_nm;
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      n_vec++;
      if (m_c.got !== m_c.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", m_c.nm, m_c.got, m_c.exp);
      end
    end
    if (ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: got read_data %h expected no response", read_data);
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = nm_q.pop_front();
        if (read_data !== m_e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", m_nm, read_data, m_e);
        end
      end
      acks++;
    end else if (read_data !== 32'd0) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_read_data: got %h expected 00000000 while ready low", read_data);
    end
  end

  // Counts cycles in which busy is low while the stimulus thread has watch set.
  logic watch = 1'b0;
  int   busy_lows = 0;
  always @(negedge clk) begin
    if (watch && !busy) busy_lows++;
  end

  // Reference model state
  logic [31:0] m_dvd = 32'd0;
  logic [31:0] m_q   = 32'd0;
  logic [31:0] m_r   = 32'd0;
  int          lat;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input bit sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.nm  = nm;
    c.got = got;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  // One bus access. lat = cycles from the en cycle to the ready cycle.
  task automatic access(input logic we, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm, output int l);
    int a0;
    @(posedge clk); #1;
    en = 1'b1; write_en = we; address = a; write_data = d;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    a0 = acks;
    @(posedge clk); #1;
    en = 1'b0; write_en = 1'b0; address = 3'd0; write_data = 32'd0;
    l = 0;
    while (acks == a0 && l < 200) begin
      @(negedge clk); #1;
      l++;
    end
    post({nm, "_acked"}, 32'(acks != a0), 32'd1);
    if (acks == a0) begin
      void'(exp_q.pop_back());
      void'(nm_q.pop_back());
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string nm);
    access(1'b1, a, d, 32'd0, nm, lat);
    if (a == 3'd0) m_dvd = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    access(1'b0, a, 32'd0, exp, nm, lat);
  endtask

  task automatic start(input bit sgn, input logic [31:0] b, input string nm);
    ref_div(m_dvd, b, sgn, m_q, m_r);
    wr(sgn ? 3'd2 : 3'd1, b, nm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    post("wait_idle", 32'(busy), 32'd0);
  endtask

  int          nb;
  int          lows0;
  logic [31:0] ra, rb;
  bit          rs;
  int          t;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    post("rst_ready", 32'(ready), 32'd0);
    post("rst_busy", 32'(busy), 32'd0);
    post("rst_read_data", read_data, 32'd0);
    resetn = 1'b1;
    rd(3'd0, 32'd0, "rst_dividend");
    rd(3'd4, 32'd0, "rst_quotient");
    rd(3'd5, 32'd0, "rst_remainder");
    rd(3'd6, 32'd0, "rst_status");

    // Unsigned 100 / 7 with busy-length check
    wr(3'd0, 32'd100, "wr_dvd_100");
    start(1'b0, 32'd7, "start_u_7");
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk); #1;
    end
    post("busy_cycles", 32'(nb), 32'd33);
    rd(3'd4, 32'd14, "u100_7_q");
    rd(3'd5, 32'd2, "u100_7_r");
    rd(3'd6, 32'd0, "status_idle");

    // Signed cases, read immediately (stalling)
    wr(3'd0, 32'hFFFF_FFF9, "wr_dvd_m7");
    start(1'b1, 32'd2, "start_s_2");
    rd(3'd4, 32'hFFFF_FFFD, "sm7_2_q");
    rd(3'd5, 32'hFFFF_FFFF, "sm7_2_r");
    wr(3'd0, 32'd7, "wr_dvd_7");
    start(1'b1, 32'hFFFF_FFFE, "start_s_m2");
    rd(3'd4, 32'hFFFF_FFFD, "s7_m2_q");
    rd(3'd5, 32'd1, "s7_m2_r");

    // Divide by zero, both modes
    wr(3'd0, 32'h1234_5678, "wr_dvd_div0");
    start(1'b0, 32'd0, "start_u_0");
    rd(3'd4, 32'hFFFF_FFFF, "u_div0_q");
    rd(3'd5, 32'h1234_5678, "u_div0_r");
    start(1'b1, 32'd0, "start_s_0");
    rd(3'd4, 32'hFFFF_FFFF, "s_div0_q");
    rd(3'd5, 32'h1234_5678, "s_div0_r");

    // Signed overflow and unsigned max / 1
    wr(3'd0, 32'h8000_0000, "wr_dvd_min");
    start(1'b1, 32'hFFFF_FFFF, "start_s_m1");
    rd(3'd4, 32'h8000_0000, "ovf_q");
    rd(3'd5, 32'd0, "ovf_r");
    wr(3'd0, 32'hFFFF_FFFF, "wr_dvd_max");
    start(1'b0, 32'd1, "start_u_1");
    rd(3'd4, 32'hFFFF_FFFF, "umax_1_q");
    rd(3'd5, 32'd0, "umax_1_r");

    // Quotient read issued 2 cycles after start stalls until after FIXUP
    wr(3'd0, 32'hDEAD_BEEF, "wr_dvd_stall");
    start(1'b0, 32'h0000_1234, "start_stall");
    access(1'b0, 3'd4, 32'd0, m_q, "stall_q", lat);
    post("stall_latency", 32'(lat), 32'd32);
    rd(3'd5, m_r, "stall_r");

    // Restart 10 cycles into 1000/3 with START_U = 10
    wr(3'd0, 32'd1000, "wr_dvd_1000");
    start(1'b0, 32'd3, "start_u_3");
    watch = 1'b1;
    lows0 = busy_lows;
    repeat (8) @(posedge clk);
    start(1'b0, 32'd10, "restart_u_10");
    rd(3'd6, 32'd1, "status_busy");
    @(negedge clk); #1;
    watch = 1'b0;
    post("busy_continuous", 32'(busy_lows - lows0), 32'd0);
    access(1'b0, 3'd4, 32'd0, 32'd100, "restart_q", lat);
    post("restart_latency", 32'(lat), 32'd29);
    rd(3'd5, 32'd0, "restart_r");

    // Ignored writes, zero reads, dividend write while busy
    wr(3'd4, 32'hA5A5_A5A5, "wr_quotient_ignored");
    wr(3'd7, 32'h5A5A_5A5A, "wr_7_ignored");
    wr(3'd3, 32'h1111_1111, "wr_3_ignored");
    rd(3'd4, 32'd100, "q_after_ignored_wr");
    rd(3'd1, 32'd0, "rd_start_u_zero");
    rd(3'd2, 32'd0, "rd_start_s_zero");
    rd(3'd3, 32'd0, "rd_3_zero");
    wr(3'd0, 32'd500, "wr_dvd_500");
    start(1'b0, 32'd7, "start_u_7b");
    wr(3'd0, 32'h55, "wr_dvd_busy");
    rd(3'd4, 32'd71, "busy_dvd_q");
    rd(3'd5, 32'd3, "busy_dvd_r");
    rd(3'd0, 32'h55, "dvd_readback");

    // Reset mid-divide
    wr(3'd0, 32'd1000, "wr_dvd_rst");
    start(1'b0, 32'd3, "start_rst");
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    m_dvd = 32'd0; m_q = 32'd0; m_r = 32'd0;
    post("midrst_ready", 32'(ready), 32'd0);
    post("midrst_busy", 32'(busy), 32'd0);
    post("midrst_read_data", read_data, 32'd0);
    rd(3'd6, 32'd0, "midrst_status");
    rd(3'd4, 32'd0, "midrst_quotient");
    rd(3'd5, 32'd0, "midrst_remainder");
    rd(3'd0, 32'd0, "midrst_dividend");
    wr(3'd0, 32'd1000, "wr_dvd_post_rst");
    start(1'b0, 32'd3, "start_post_rst");
    rd(3'd4, 32'd333, "post_rst_q");
    rd(3'd5, 32'd1, "post_rst_r");

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: begin t = int'($urandom_range(0, 40)) - 20; ra = 32'(t); end
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      wr(3'd0, ra, "rnd_wr_dvd");
      start(rs, rb, "rnd_start");
      repeat ($urandom_range(0, 40)) @(posedge clk);
      rd(3'd4, m_q, "rnd_q");
      rd(3'd5, m_r, "rnd_r");
    end
    wait_idle();

    post("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
